// File: rtl/nios_multi_timer_pkg.sv
// nios_multi_timer_pkg: register offsets and bit indices shared by the multi-channel timer
package nios_multi_timer_pkg;
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;
  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;
endpackage

// File: rtl/nios_timer_channel.sv
// nios_timer_channel: one down-counter channel with period, snapshot, control and TO/RUN
// Ports: we_i/off_i/wdata_i decoded write for this channel, rdata_o read value at off_i, irq_o TO&ITO.
// Optional prescaler enabled by TIMER_PRESCALER_EN.
module nios_timer_channel
  import nios_multi_timer_pkg::*;
#(
  parameter int COUNTER_W = 32,
  parameter longint unsigned RESET_PERIOD = 49999,
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [2:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);
  logic [COUNTER_W-1:0] count_q, count_d, period_q, period_d, snap_q, snap_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic run_q, run_d, to_q, to_d, reload_q;
  logic [63:0] per_ext, snap_ext;
  logic [31:0] presc_rd;
  logic wr_ctl, wr_per, start, stop, tick, step, timeout;
  assign per_ext  = 64'(period_q);
  assign snap_ext = 64'(snap_q);
  assign wr_ctl   = we_i && off_i == REG_CONTROL;
  assign wr_per   = we_i && (off_i == REG_PERIOD_L || off_i == REG_PERIOD_H);
  assign start    = wr_ctl & wdata_i[CTRL_START];
  assign stop     = wr_ctl & wdata_i[CTRL_STOP];
  assign step     = run_q & tick;
  // a pending force reload overrides counting on its edge, so no timeout is taken there
  assign timeout  = step & ~reload_q & (count_q == '0);
  assign count_d  = (reload_q | timeout) ? period_q : step ? count_q - 1'b1 : count_q;
  assign period_d = wr_per ? COUNTER_W'(off_i == REG_PERIOD_H ? {wdata_i, per_ext[31:0]}
                                                              : {per_ext[63:32], wdata_i}) : period_q;
  assign snap_d   = (we_i && (off_i == REG_SNAP_L || off_i == REG_SNAP_H)) ? count_q : snap_q;
  assign ctrl_d   = wr_ctl ? wdata_i[3:0] : ctrl_q;
  assign run_d    = reload_q ? 1'b0 : start ? 1'b1 : stop ? 1'b0 : timeout ? ctrl_q[CTRL_CONT] : run_q;
  assign to_d     = timeout ? 1'b1 : (we_i && off_i == REG_STATUS) ? 1'b0 : to_q;
  assign irq_o    = to_q & ctrl_q[CTRL_ITO];
  assign rdata_o  = off_i == REG_STATUS   ? (32'(run_q) << STAT_RUN) | (32'(to_q) << STAT_TO) :
                    off_i == REG_CONTROL  ? 32'(ctrl_q) :
                    off_i == REG_PERIOD_L ? per_ext[31:0] :
                    off_i == REG_PERIOD_H ? per_ext[63:32] :
                    off_i == REG_SNAP_L   ? snap_ext[31:0] :
                    off_i == REG_SNAP_H   ? snap_ext[63:32] :
                    off_i == REG_PRESCALE ? presc_rd : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= COUNTER_W'(RESET_PERIOD);
      period_q <= COUNTER_W'(RESET_PERIOD);
      snap_q   <= '0;
      ctrl_q   <= '0;
      run_q    <= 1'b0;
      to_q     <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      snap_q   <= snap_d;
      ctrl_q   <= ctrl_d;
      run_q    <= run_d;
      to_q     <= to_d;
      reload_q <= wr_per;
    end
  end
`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] presc_q, pcnt_q;
  assign tick     = pcnt_q >= presc_q;
  assign presc_rd = 32'(presc_q);
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= (we_i && off_i == REG_PRESCALE) ? wdata_i[PRESCALE_W-1:0] : presc_q;
      pcnt_q  <= (reload_q | start | tick | ~run_q) ? '0 : pcnt_q + 1'b1;
    end
  end
`else
  logic unused_pw;
  assign tick      = 1'b1;
  assign presc_rd  = '0;
  assign unused_pw = |PRESCALE_W;
`endif
endmodule

// File: rtl/nios_multi_timer.sv
// nios_multi_timer: multi-channel Avalon-MM interval timer with per-channel and combined irq
// Ports: address [2:0]=register, upper bits=channel; chipselect/write_n/writedata write port;
// readdata registered 1-cycle read; irq_vec per channel; irq OR of irq_vec.
// Optional prescaler enabled by TIMER_PRESCALER_EN.
module nios_multi_timer
  import nios_multi_timer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int COUNTER_W = 32,
  parameter longint unsigned RESET_PERIOD = 49999,
  parameter int PRESCALE_W = 16,
  localparam int AW = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);
  logic [31:0] ch_rd [NUM_CH];
  logic [31:0] rd_d;
  int sel;
  assign sel = int'(address >> 3);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    nios_timer_channel #(
      .COUNTER_W(COUNTER_W),
      .RESET_PERIOD(RESET_PERIOD),
      .PRESCALE_W(PRESCALE_W)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .we_i(chipselect & ~write_n & (sel == i)),
      .off_i(address[2:0]),
      .wdata_i(writedata),
      .rdata_o(ch_rd[i]),
      .irq_o(irq_vec[i])
    );
  end
  always_comb begin
    rd_d = '0;
    for (int c = 0; c < NUM_CH; c++) rd_d = (sel == c) ? ch_rd[c] : rd_d;
  end
  assign irq = |irq_vec;
  always_ff @(posedge clk) readdata <= reset ? '0 : rd_d;
endmodule

// File: tb/tb_nios_multi_timer.sv
// tb_nios_multi_timer: directed and randomized checks of nios_multi_timer against an arithmetic timeout model
module tb_nios_multi_timer;
  import nios_multi_timer_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic a_cs = 1'b0, a_wn = 1'b1, b_cs = 1'b0, b_wn = 1'b1;
  logic [3:0] a_addr = '0;
  logic [4:0] b_addr = '0;
  logic [31:0] wd = '0, a_rd, b_rd, v;
  logic [1:0] a_irqv;
  logic [2:0] b_irqv;
  logic a_irq, b_irq;
  int checks = 0, errors = 0, edges = 0;
  int t0, k, p, clr, n;
  bit cont, e;
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  nios_multi_timer dut (.clk(clk), .reset(reset), .address(a_addr), .chipselect(a_cs), .write_n(a_wn),
    .writedata(wd), .readdata(a_rd), .irq_vec(a_irqv), .irq(a_irq));
  nios_multi_timer #(.NUM_CH(3), .COUNTER_W(40)) dut40 (.clk(clk), .reset(reset), .address(b_addr),
    .chipselect(b_cs), .write_n(b_wn), .writedata(wd), .readdata(b_rd), .irq_vec(b_irqv), .irq(b_irq));
  // TO after edge k of a run started at k=0 with period p, last cleared at edge clr
  function automatic bit exp_to(int k, int p, int clr, bit cont);
    int lt = cont ? (k / (p + 1)) * (p + 1) : (k >= p + 1 ? p + 1 : 0);
    return lt > 0 && lt >= clr;
  endfunction
  function automatic int exp_cnt(int k, int p, bit cont);
    return (cont || k < p + 1) ? p - (k % (p + 1)) : p;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input bit b, input int ch, input int off, input logic [31:0] d);
    @(negedge clk);
    if (b) begin b_cs = 1'b1; b_wn = 1'b0; b_addr = 5'(ch * 8 + off); end
    else begin a_cs = 1'b1; a_wn = 1'b0; a_addr = 4'(ch * 8 + off); end
    wd = d;
    @(posedge clk);
    #1;
    a_cs = 1'b0; a_wn = 1'b1; b_cs = 1'b0; b_wn = 1'b1;
  endtask
  task automatic rd(input bit b, input int ch, input int off, output logic [31:0] d);
    @(negedge clk);
    if (b) b_addr = 5'(ch * 8 + off);
    else a_addr = 4'(ch * 8 + off);
    @(posedge clk);
    #1;
    d = b ? b_rd : a_rd;
  endtask
  task automatic watch1(input int n, input int p, input bit cont, input int t0, input int clr);
    for (int c = 0; c < n; c++) begin
      step();
      chk("ch1_irq_vec", a_irqv[1], exp_to(edges - t0, p, clr, cont));
      chk("ch1_irq", a_irq, exp_to(edges - t0, p, clr, cont));
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readdata", a_rd, 0);
    chk("rst_irq", a_irq, 0);
    chk("rst_irq_vec", a_irqv, 0);
    reset = 1'b0;
    rd(0, 0, REG_PERIOD_L, v); chk("rst_period_l", v, 49999);
    rd(0, 0, REG_STATUS, v);   chk("rst_status", v, 0);
    rd(0, 0, REG_PERIOD_H, v); chk("period_h_w32", v, 0);
    rd(0, 0, 7, v);            chk("reserved", v, 0);
    // continuous ch1, period 4
    wr(0, 1, REG_PERIOD_L, 4); step(); wr(0, 1, REG_CONTROL, 7); t0 = edges;
    watch1(12, 4, 1, t0, 0);
    while ((edges - t0) % 5 != 4) step();
    wr(0, 1, REG_STATUS, 0); clr = edges - t0;
    chk("clear_at_timeout", a_irqv[1], 1);
    step(); step();
    wr(0, 1, REG_STATUS, 0); clr = edges - t0;
    chk("clear_between", a_irqv[1], 0);
    watch1(8, 4, 1, t0, clr);
    // one-shot ch0, period 3
    wr(0, 0, REG_PERIOD_L, 3); step(); wr(0, 0, REG_CONTROL, 4);
    repeat (10) step();
    rd(0, 0, REG_STATUS, v);   chk("oneshot_status", v, 1);
    wr(0, 0, REG_STATUS, 0);
    repeat (10) step();
    rd(0, 0, REG_STATUS, v);   chk("oneshot_single", v, 0);
    wr(0, 0, REG_SNAP_L, 0);
    rd(0, 0, REG_SNAP_L, v);   chk("oneshot_count", v, 3);
    wr(0, 0, REG_CONTROL, 32'hC);
    rd(0, 0, REG_STATUS, v);   chk("start_stop_run", v, 2);
    wr(0, 0, REG_CONTROL, 32'h8);
    rd(0, 0, REG_STATUS, v);   chk("stop_run", v, 0);
    wr(0, 0, REG_SNAP_L, 0);
    rd(0, 0, REG_SNAP_L, v);   chk("stop_held", v, 1);
    // force reload collides with START
    wr(0, 0, REG_CONTROL, 4); wr(0, 0, REG_PERIOD_L, 6); wr(0, 0, REG_CONTROL, 4);
    rd(0, 0, REG_STATUS, v);   chk("reload_beats_start", v, 0);
    wr(0, 0, REG_SNAP_L, 0);
    rd(0, 0, REG_SNAP_L, v);   chk("reload_count", v, 6);
    // 40-bit instance
    wr(1, 0, REG_PERIOD_H, 32'hFF); wr(1, 0, REG_PERIOD_L, 32'h10); step();
    rd(1, 0, REG_PERIOD_H, v); chk("w40_period_h", v, 32'hFF);
    wr(1, 0, REG_CONTROL, 4); t0 = edges;
    repeat (3) step();
    wr(1, 0, REG_SNAP_H, 0); k = edges - 1 - t0;
    rd(1, 0, REG_SNAP_H, v);   chk("w40_snap_h", v, 32'hFF);
    rd(1, 0, REG_SNAP_L, v);   chk("w40_snap_l", v, 32'h10 - k);
    wr(1, 0, REG_PERIOD_H, 32'h1FF);
    rd(1, 0, REG_PERIOD_H, v); chk("w40_period_h_trunc", v, 32'hFF);
    wr(1, 3, REG_PERIOD_L, 32'h55);
    rd(1, 3, REG_PERIOD_L, v); chk("bad_channel", v, 0);
    rd(1, 2, REG_PERIOD_L, v); chk("ch2_period_l", v, 49999);
    // randomized runs on ch1
    for (int t = 0; t < 6; t++) begin
      p = $urandom_range(0, 12);
      cont = 1'($urandom_range(0, 1));
      wr(0, 1, REG_CONTROL, 8); wr(0, 1, REG_STATUS, 0); wr(0, 1, REG_PERIOD_L, p); step();
      wr(0, 1, REG_CONTROL, 32'h5 | (32'(cont) << 1)); t0 = edges; clr = 0;
      n = 2 * (p + 1) + $urandom_range(1, 8);
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 5) == 0) begin wr(0, 1, REG_STATUS, 0); clr = edges - t0; end
        else step();
        e = exp_to(edges - t0, p, clr, cont);
        chk("rand_irq_vec", a_irqv[1], e);
        chk("rand_irq", a_irq, e);
      end
      rd(0, 1, REG_STATUS, v); k = edges - 1 - t0;
      chk("rand_status", v, {30'b0, cont || k < p + 1, exp_to(k, p, clr, cont)});
      wr(0, 1, REG_SNAP_L, 0); k = edges - 1 - t0;
      rd(0, 1, REG_SNAP_L, v); chk("rand_snap", v, exp_cnt(k, p, cont));
    end
`ifdef TIMER_PRESCALER_EN
    wr(0, 0, REG_PRESCALE, 9); wr(0, 0, REG_PERIOD_L, 1); step(); wr(0, 0, REG_STATUS, 0);
    wr(0, 0, REG_CONTROL, 5); t0 = edges;
    for (int c = 0; c < 22; c++) begin
      step();
      chk("presc_irq", a_irqv[0], (edges - t0) >= 20);
    end
    rd(0, 0, REG_PRESCALE, v); chk("presc_reg", v, 9);
`else
    wr(0, 0, REG_PRESCALE, 9);
    rd(0, 0, REG_PRESCALE, v); chk("presc_absent", v, 0);
`endif
    // reset mid-count
    reset = 1'b1;
    step();
    chk("mid_rst_irq", a_irq, 0);
    chk("mid_rst_rd", a_rd, 0);
    reset = 1'b0;
    rd(0, 1, REG_STATUS, v);   chk("mid_rst_status", v, 0);
    rd(0, 1, REG_PERIOD_L, v); chk("mid_rst_period", v, 49999);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
